alu_result_fifo: RTL
====================

# alu_result_fifo

Small synchronous FIFO directly downstream of the ALU: on a write strobe it captures the ALU result word, ZERO flag and the operation code that produced them, and hands them to the writeback/consumer stage in arrival order. It decouples the combinational ALU from a consumer that cannot accept a result every cycle. It also reports occupancy and sticky overflow/underflow errors.

## Interface
- DATA_WIDTH, 32, width of the ALU result word
- OPRN_WIDTH, 6, width of the operation code
- DEPTH, 4, number of entries; power of two, ≥ 2
- CNT_WIDTH, 3, width of COUNT; must equal log2(DEPTH)+1
- CLK  input  1  clock; all state changes on the rising edge
- RST  input  1  reset, synchronous, active-high
- WR_EN  input  1  push request for the current ALU_OUT/ALU_ZERO/ALU_OPRN
- ALU_OUT  input  DATA_WIDTH  ALU result to store
- ALU_ZERO  input  1  ALU zero flag to store
- ALU_OPRN  input  OPRN_WIDTH  operation code to store
- RD_EN  input  1  pop request; consumes the head entry
- RD_DATA  output  DATA_WIDTH  head entry result; 0 when EMPTY
- RD_ZERO  output  1  head entry zero flag; 0 when EMPTY
- RD_OPRN  output  OPRN_WIDTH  head entry opcode; 0 when EMPTY
- EMPTY  output  1  no entries stored
- FULL  output  1  DEPTH entries stored
- COUNT  output  CNT_WIDTH  number of stored entries, 0..DEPTH
- OVERFLOW  output  1  sticky: a push was dropped
- UNDERFLOW  output  1  sticky: a pop was ignored

## Operation
- Storage: DEPTH entries of {OPRN, ZERO, DATA}; write pointer, read pointer, each log2(DEPTH) bits, wrapping modulo DEPTH; COUNT held in a separate register.
- First-word-fall-through: RD_DATA/RD_ZERO/RD_OPRN show the head entry whenever EMPTY=0, with no read request needed; they are forced to 0 when EMPTY=1.
- Push accepted when WR_EN=1 and (FULL=0, or RD_EN=1 with FULL=1). The entry is written at the write pointer, and the pointer advances.
- Pop accepted when RD_EN=1 and EMPTY=0. The read pointer advances.
- Counts and flags per edge:
  - push only: COUNT+1
  - pop only: COUNT−1
  - both accepted: COUNT unchanged
- Boundary cases:
  - WR_EN with FULL=1 and RD_EN=0: data dropped, storage/pointers unchanged, OVERFLOW set.
  - RD_EN with EMPTY=1: ignored, UNDERFLOW set. A simultaneous WR_EN is still accepted; COUNT becomes 1.
  - WR_EN and RD_EN both asserted with FULL=1: both accepted, COUNT stays DEPTH, FULL stays 1, head advances.
- No opcode decoding: any ALU_OPRN value, including undefined codes, is stored verbatim.
- OVERFLOW and UNDERFLOW stay set until RST. They have no other clear.
- EMPTY = (COUNT==0), FULL = (COUNT==DEPTH). Both are derived from registered COUNT, so there is no combinational path from WR_EN/RD_EN to the status outputs.

## Timing
- RST=1 at a rising edge clears pointers, COUNT=0, EMPTY=1, FULL=0, OVERFLOW=0, UNDERFLOW=0, RD_DATA=0, RD_ZERO=0, RD_OPRN=0.
- Storage contents are not reset.
- RST takes priority over WR_EN/RD_EN in the same cycle. RST mid-stream discards all entries.
- Write-to-read latency is 1 cycle: data pushed at edge N appears on RD_* and EMPTY falls after edge N.
- Pop takes effect at the edge. The next entry, or the forced 0s, appear after that edge.
- Inputs are sampled only at the rising edge. ALU_* may change freely between edges.

## Test plan
- Reset, then push 18/ZERO=0/OPRN=0x01 (15+3) → one cycle later EMPTY=0, COUNT=1, RD_DATA=18, RD_ZERO=0, RD_OPRN=0x01.
- Push four entries, one per cycle:
  - 10/0/0x02
  - 75/0/0x03
  - 0/1/0x03
  - 0/1/0x04

  Expect FULL=1 and COUNT=4. Then pop four times → RD_* show the entries in order, then EMPTY=1 with RD_*=0.
- While FULL, assert WR_EN with 1/0/0x09 and RD_EN=0 → OVERFLOW=1, COUNT=4, contents unchanged. Pop all four → original four entries returned in order, no 1/0/0x09.
- While FULL, assert WR_EN (480/0/0x05) and RD_EN together → COUNT=4, FULL=1, head advances. After three further pops, RD_DATA=480, RD_OPRN=0x05.
- While EMPTY, assert RD_EN and WR_EN (5/0/0x06) together → UNDERFLOW=1, COUNT=1, RD_DATA=5.
- With 3 entries stored and both sticky flags set, assert RST for one cycle → COUNT=0, EMPTY=1, OVERFLOW=0, UNDERFLOW=0, RD_*=0. Push 0xFFFFFFF0/0/0x08 → it is returned as the head with correct wrap-around of the pointers.

Source files
------------

// File: rtl/alu_result_fifo.sv
// First-word-fall-through FIFO between the ALU and the writeback stage.
// Holds {opcode, zero flag, result} and reports occupancy plus sticky overflow/underflow.
module alu_result_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int OPRN_WIDTH = 6,
    parameter int DEPTH      = 4,
    parameter int CNT_WIDTH  = 3
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  WR_EN,
    input  logic [DATA_WIDTH-1:0] ALU_OUT,
    input  logic                  ALU_ZERO,
    input  logic [OPRN_WIDTH-1:0] ALU_OPRN,
    input  logic                  RD_EN,
    output logic [DATA_WIDTH-1:0] RD_DATA,
    output logic                  RD_ZERO,
    output logic [OPRN_WIDTH-1:0] RD_OPRN,
    output logic                  EMPTY,
    output logic                  FULL,
    output logic [CNT_WIDTH-1:0]  COUNT,
    output logic                  OVERFLOW,
    output logic                  UNDERFLOW
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int ENTRY_W = OPRN_WIDTH + 1 + DATA_WIDTH;

    logic [ENTRY_W-1:0]    mem_q [DEPTH];
    logic [ENTRY_W-1:0]    mem_d [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_WIDTH-1:0]  count_q, count_d;
    logic                  empty_q, empty_d;
    logic                  full_q, full_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  rd_zero_q, rd_zero_d;
    logic [OPRN_WIDTH-1:0] rd_oprn_q, rd_oprn_d;

    logic                  push_s;
    logic                  pop_s;
    logic [ENTRY_W-1:0]    wr_entry_s;
    logic [ENTRY_W-1:0]    head_entry_s;

    // Accept/reject decisions, pointer and occupancy next-state
    always_comb begin
        push_s     = WR_EN && (!full_q || RD_EN);
        pop_s      = RD_EN && !empty_q;
        wr_entry_s = {ALU_OPRN, ALU_ZERO, ALU_OUT};

        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_WIDTH'(1);
            2'b01:   count_d = count_q - CNT_WIDTH'(1);
            default: count_d = count_q;
        endcase

        empty_d     = (count_d == CNT_WIDTH'(0));
        full_d      = (count_d == CNT_WIDTH'(DEPTH));
        overflow_d  = overflow_q  || (WR_EN && full_q && !RD_EN);
        underflow_d = underflow_q || (RD_EN && empty_q);
    end

    // Storage write and next head entry; a slot being written this edge bypasses the array
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (push_s && !RST) begin
            mem_d[wr_ptr_q] = wr_entry_s;
        end else begin
            mem_d[wr_ptr_q] = mem_q[wr_ptr_q];
        end

        if (empty_d) begin
            head_entry_s = {ENTRY_W{1'b0}};
        end else if (push_s && (wr_ptr_q == rd_ptr_d)) begin
            head_entry_s = wr_entry_s;
        end else begin
            head_entry_s = mem_q[rd_ptr_d];
        end

        rd_data_d = head_entry_s[DATA_WIDTH-1:0];
        rd_zero_d = head_entry_s[DATA_WIDTH];
        rd_oprn_d = head_entry_s[ENTRY_W-1:DATA_WIDTH+1];
    end

    // Entry storage, intentionally left out of reset
    always_ff @(posedge CLK) begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
        end
    end

    // Control and output registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_q    <= {PTR_W{1'b0}};
            rd_ptr_q    <= {PTR_W{1'b0}};
            count_q     <= {CNT_WIDTH{1'b0}};
            empty_q     <= 1'b1;
            full_q      <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            rd_data_q   <= {DATA_WIDTH{1'b0}};
            rd_zero_q   <= 1'b0;
            rd_oprn_q   <= {OPRN_WIDTH{1'b0}};
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            empty_q     <= empty_d;
            full_q      <= full_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            rd_data_q   <= rd_data_d;
            rd_zero_q   <= rd_zero_d;
            rd_oprn_q   <= rd_oprn_d;
        end
    end

    assign RD_DATA   = rd_data_q;
    assign RD_ZERO   = rd_zero_q;
    assign RD_OPRN   = rd_oprn_q;
    assign EMPTY     = empty_q;
    assign FULL      = full_q;
    assign COUNT     = count_q;
    assign OVERFLOW  = overflow_q;
    assign UNDERFLOW = underflow_q;

endmodule
